// File: rtl/rng_bit_harvester_if.sv
// Control, status and byte-output signals of the raw-bit harvester.
// The harvester drives the slave outputs; the host/control side uses master.
interface rng_bit_harvester_if;
    logic       en;
    logic       rng_in;
    logic       bypass_vn;
    logic       clr_fail;
    logic       byte_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       health_fail;
    logic [7:0] drop_cnt;

    modport master (
        output en, rng_in, bypass_vn, clr_fail, byte_ready,
        input  byte_out, byte_valid, health_fail, drop_cnt
    );

    modport slave (
        input  en, rng_in, bypass_vn, clr_fail, byte_ready,
        output byte_out, byte_valid, health_fail, drop_cnt
    );
endinterface

// File: rtl/rng_bit_harvester.sv
// Samples a free-running raw bit, health-tests it, debiases it and packs MSB-first bytes.
// Byte is valid the cycle after its completing strobe; a full, unaccepted output register drops new bytes and counts them.
module rng_bit_harvester #(
    parameter int DIV       = 4,
    parameter int RCT_LIMIT = 32
) (
    input  logic               clk,
    input  logic               rst,
    rng_bit_harvester_if.slave bus
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = $clog2(RCT_LIMIT + 1);
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);
    localparam logic [RW-1:0] RCT_MAX  = RW'(RCT_LIMIT);

    logic          s1_q, s2_q;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          last_smp_q, last_smp_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_nxt;
    logic          health_fail_q, health_fail_d;
    logic          ph_q, ph_d;
    logic          first_q, first_d;
    logic          bypass_q;
    logic [7:0]    sreg_q, sreg_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    byte_out_q, byte_out_d;
    logic          byte_valid_q, byte_valid_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic       stb, smp, trip;
    logic       emit, emit_bit, emit_g;
    logic       byte_done, load, xfer;
    logic [7:0] new_byte;

    always_comb begin
        stb    = bus.en && (pcnt_q == PCNT_MAX);
        smp    = s2_q;
        pcnt_d = (!bus.en || stb) ? '0 : pcnt_q + PW'(1);

        // rep_cnt of zero marks "no sample yet" after reset or clear
        if (rep_cnt_q == '0 || smp != last_smp_q) begin
            rep_nxt = RW'(1);
        end else if (rep_cnt_q < RCT_MAX) begin
            rep_nxt = rep_cnt_q + RW'(1);
        end else begin
            rep_nxt = rep_cnt_q;
        end
        trip          = stb && (rep_nxt == RCT_MAX);
        rep_cnt_d     = bus.clr_fail ? '0 : (stb ? rep_nxt : rep_cnt_q);
        last_smp_d    = stb ? smp : last_smp_q;
        health_fail_d = trip ? 1'b1 : (bus.clr_fail ? 1'b0 : health_fail_q);

        ph_d     = ph_q;
        first_d  = first_q;
        emit     = 1'b0;
        emit_bit = smp;
        if (stb) begin
            if (bus.bypass_vn) begin
                emit = 1'b1;
            end else if (!ph_q) begin
                first_d = smp;
                ph_d    = 1'b1;
            end else begin
                ph_d     = 1'b0;
                emit     = (first_q != smp);
                emit_bit = first_q;
            end
        end
        if (!bus.en || (bus.bypass_vn != bypass_q)) begin
            ph_d = 1'b0;
        end
        emit_g = emit && !health_fail_q;

        new_byte  = {sreg_q[6:0], emit_bit};
        sreg_d    = sreg_q;
        bcnt_d    = bcnt_q;
        byte_done = 1'b0;
        if (emit_g) begin
            sreg_d = new_byte;
            if (bcnt_q == 3'd7) begin
                byte_done = 1'b1;
                bcnt_d    = 3'd0;
            end else begin
                bcnt_d = bcnt_q + 3'd1;
            end
        end

        // A byte may load into a register that is emptying on this same edge
        xfer         = byte_valid_q && bus.byte_ready;
        load         = byte_done && (!byte_valid_q || bus.byte_ready);
        byte_valid_d = load ? 1'b1 : (xfer ? 1'b0 : byte_valid_q);
        byte_out_d   = load ? new_byte : byte_out_q;
        drop_cnt_d   = (byte_done && !load && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            pcnt_q        <= '0;
            last_smp_q    <= 1'b0;
            rep_cnt_q     <= '0;
            health_fail_q <= 1'b0;
            ph_q          <= 1'b0;
            first_q       <= 1'b0;
            bypass_q      <= 1'b0;
            sreg_q        <= 8'h00;
            bcnt_q        <= 3'd0;
            byte_out_q    <= 8'h00;
            byte_valid_q  <= 1'b0;
            drop_cnt_q    <= 8'h00;
        end else begin
            s1_q          <= bus.rng_in;
            s2_q          <= s1_q;
            pcnt_q        <= pcnt_d;
            last_smp_q    <= last_smp_d;
            rep_cnt_q     <= rep_cnt_d;
            health_fail_q <= health_fail_d;
            ph_q          <= ph_d;
            first_q       <= first_d;
            bypass_q      <= bus.bypass_vn;
            sreg_q        <= sreg_d;
            bcnt_q        <= bcnt_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign bus.byte_out    = byte_out_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.health_fail = health_fail_q;
    assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_rng_bit_harvester.sv
// Bench for rng_bit_harvester: raw bits are held DIV cycles aligned to the strobe and
// the resulting bytes are compared against a per-sample reference model.
module tb_rng_bit_harvester;

    localparam int DIV = 4;
    localparam int RCT = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rng_bit_harvester_if bus ();

    rng_bit_harvester #(.DIV(DIV), .RCT_LIMIT(RCT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         vld_cycles = 0;

    // Reference model state: run length, sticky failure, pending pair, partial byte
    bit         m_last;
    int         m_run;
    bit         m_fail;
    bit         m_have;
    bit         m_first;
    logic [7:0] m_acc;
    int         m_n;

    always begin
        @(negedge clk);
        #1;
        if (!rst && bus.byte_valid) begin
            vld_cycles++;
            if (bus.byte_ready) got_q.push_back(bus.byte_out);
        end
    end

    task automatic model_reset();
        m_last = 1'b0;
        m_run  = 0;
        m_fail = 1'b0;
        m_have = 1'b0;
        m_first = 1'b0;
        m_acc  = 8'h00;
        m_n    = 0;
        exp_q.delete();
    endtask

    task automatic model_sample(input bit b, input bit clr);
        bit emit, ebit, trip;
        emit = 1'b0;
        ebit = b;
        if (bus.bypass_vn) begin
            emit = 1'b1;
        end else if (!m_have) begin
            m_first = b;
            m_have  = 1'b1;
        end else begin
            m_have = 1'b0;
            if (m_first != b) begin
                emit = 1'b1;
                ebit = m_first;
            end
        end
        if (emit && !m_fail) begin
            m_acc = {m_acc[6:0], ebit};
            m_n++;
            if (m_n == 8) begin
                exp_q.push_back(m_acc);
                m_n = 0;
            end
        end
        if (m_run == 0 || b != m_last) m_run = 1;
        else if (m_run < RCT) m_run++;
        m_last = b;
        trip = (m_run == RCT);
        if (clr) begin
            m_run  = 0;
            m_fail = trip;
        end else if (trip) begin
            m_fail = 1'b1;
        end
    endtask

    // Called at a negedge; returns at the negedge following the strobe that samples b
    task automatic feed_bit(input bit b, input bit rdy_at_stb, input bit clr_at_stb);
        bus.rng_in = b;
        bus.en     = 1'b1;
        repeat (DIV - 1) @(negedge clk);
        if (rdy_at_stb) bus.byte_ready = 1'b1;
        if (clr_at_stb) bus.clr_fail = 1'b1;
        @(negedge clk);
        bus.clr_fail = 1'b0;
        model_sample(b, clr_at_stb);
    endtask

    task automatic feed_end();
        bus.en = 1'b0;
        m_have = 1'b0;
        @(negedge clk);
    endtask

    task automatic feed_seq(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) feed_bit(v[i], 1'b0, 1'b0);
    endtask

    task automatic clr_pulse();
        bus.clr_fail = 1'b1;
        @(negedge clk);
        bus.clr_fail = 1'b0;
        m_run  = 0;
        m_fail = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte_out: got %0h expected 0", bus.byte_out); end
        n_checks++; if (bus.byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid: got %0b expected 0", bus.byte_valid); end
        n_checks++; if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_health_fail: got %0b expected 0", bus.health_fail); end
        n_checks++; if (bus.drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", bus.drop_cnt); end
        rst = 1'b0;
        model_reset();
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            bus.rng_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.byte_valid !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_valid: got %0d valid cycles expected 0", bad); end
        n_checks++; if (dut.rep_cnt_q !== '0) begin n_fail++; $display("FAIL idle_rep_cnt: got %0d expected 0", dut.rep_cnt_q); end
    endtask

    task automatic test_debias();
        logic [15:0] seq;
        seq = 16'h9966;
        bus.bypass_vn = 1'b0;
        bus.byte_ready = 1'b1;
        got_q.delete(); vld_cycles = 0;
        feed_seq({48'h0, seq}, 16);
        feed_end();
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL debias_count: got %0d bytes expected 1", got_q.size()); end
        n_checks++; if (got_q.size() > 0 && got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL debias_byte: got %0h expected a5", got_q[0]); end
        n_checks++; if (vld_cycles !== 1) begin n_fail++; $display("FAIL debias_valid_len: got %0d cycles expected 1", vld_cycles); end
        n_checks++; if (bus.drop_cnt !== 8'h00) begin n_fail++; $display("FAIL debias_drop: got %0d expected 0", bus.drop_cnt); end

        got_q.delete(); vld_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) begin
                bit p;
                p = 1'($urandom_range(0, 1));
                feed_bit(p, 1'b0, 1'b0);
                feed_bit(p, 1'b0, 1'b0);
            end
            feed_bit(seq[15 - 2 * i], 1'b0, 1'b0);
            feed_bit(seq[14 - 2 * i], 1'b0, 1'b0);
        end
        feed_end();
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL debias_pad_count: got %0d bytes expected 1", got_q.size()); end
        n_checks++; if (got_q.size() > 0 && got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL debias_pad_byte: got %0h expected a5", got_q[0]); end
    endtask

    task automatic test_bypass();
        bus.bypass_vn = 1'b1;
        got_q.delete();
        feed_seq(64'hCE, 8);
        feed_end();
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL bypass_count: got %0d bytes expected 1", got_q.size()); end
        n_checks++; if (got_q.size() > 0 && got_q[0] !== 8'hCE) begin n_fail++; $display("FAIL bypass_byte: got %0h expected ce", got_q[0]); end
    endtask

    task automatic test_random();
        for (int mode = 0; mode < 2; mode++) begin
            bus.bypass_vn = 1'(mode);
            got_q.delete(); exp_q.delete();
            for (int i = 0; i < 200; i++) feed_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            feed_end();
            repeat (3) @(negedge clk);
            n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random_count mode %0d: got %0d bytes expected %0d", mode, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_byte mode %0d idx %0d: got %0h expected %0h", mode, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        bus.bypass_vn = 1'b1;
        got_q.delete(); exp_q.delete();
        bus.byte_ready = 1'b0;
        guard = 0;
        while (exp_q.size() < 3 && guard < 64) begin feed_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0); guard++; end
        n_checks++; if (exp_q.size() !== 3) begin n_fail++; $display("FAIL bp_setup: got %0d model bytes expected 3", exp_q.size()); end
        if (exp_q.size() >= 3) begin
            n_checks++; if (bus.byte_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b expected 1", bus.byte_valid); end
            n_checks++; if (bus.byte_out !== exp_q[0]) begin n_fail++; $display("FAIL bp_hold: got %0h expected %0h", bus.byte_out, exp_q[0]); end
            n_checks++; if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_drop: got %0d expected 2", bus.drop_cnt); end
            for (int i = 0; i < 7; i++) feed_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            feed_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0);
            n_checks++; if (bus.byte_valid !== 1'b1) begin n_fail++; $display("FAIL bp_simul_valid: got %0b expected 1", bus.byte_valid); end
            n_checks++; if (exp_q.size() < 4 || bus.byte_out !== exp_q[3]) begin n_fail++; $display("FAIL bp_simul_byte: got %0h expected %0h", bus.byte_out, exp_q[exp_q.size() - 1]); end
            feed_end();
            repeat (3) @(negedge clk);
            n_checks++; if (got_q.size() !== 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[3]) begin n_fail++; $display("FAIL bp_transfers: got %0d bytes expected 2 (%0h,%0h)", got_q.size(), exp_q[0], exp_q[3]); end
            n_checks++; if (bus.drop_cnt !== 8'd2) begin n_fail++; $display("FAIL bp_drop_after: got %0d expected 2", bus.drop_cnt); end
        end else begin
            feed_end();
        end
    endtask

    task automatic test_drop_saturate();
        bus.bypass_vn = 1'b1;
        bus.byte_ready = 1'b0;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 300 * 8; i++) feed_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        feed_end();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_saturate: got %0d expected 255", bus.drop_cnt); end
        n_checks++; if (bus.byte_valid !== 1'b1) begin n_fail++; $display("FAIL drop_valid: got %0b expected 1", bus.byte_valid); end
        n_checks++; if (exp_q.size() == 0 || bus.byte_out !== exp_q[0]) begin n_fail++; $display("FAIL drop_hold: got %0h expected first byte of burst", bus.byte_out); end
        bus.byte_ready = 1'b1;
        repeat (3) @(negedge clk);
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_health();
        int n0, v0;
        bus.bypass_vn = 1'b1;
        bus.byte_ready = 1'b1;
        got_q.delete(); exp_q.delete();
        feed_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) feed_bit(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL health_early: got %0b expected 0 after 31 repeats", bus.health_fail); end
        feed_bit(1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.health_fail !== 1'b1) begin n_fail++; $display("FAIL health_trip: got %0b expected 1 after 32 repeats", bus.health_fail); end
        feed_end();
        repeat (3) @(negedge clk);
        n0 = got_q.size(); v0 = vld_cycles;
        for (int i = 0; i < 16; i++) feed_bit(1'b1, 1'b0, 1'b0);
        feed_end();
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() !== n0 || vld_cycles !== v0) begin n_fail++; $display("FAIL health_gate: got %0d bytes expected %0d", got_q.size(), n0); end
        clr_pulse();
        n_checks++; if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL health_clear: got %0b expected 0", bus.health_fail); end
        for (int i = 0; i < 31; i++) feed_bit(1'b1, 1'b0, 1'b0);
        feed_bit(1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.health_fail !== 1'b1) begin n_fail++; $display("FAIL health_trip_wins: got %0b expected 1", bus.health_fail); end
        feed_end();
        clr_pulse();
        n_checks++; if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL health_clear2: got %0b expected 0", bus.health_fail); end
        for (int i = 0; i < 40; i++) feed_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        feed_end();
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL health_resume_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL health_resume_byte idx %0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        logic [7:0] v;
        bus.bypass_vn = 1'b1;
        bus.byte_ready = 1'b0;
        got_q.delete(); exp_q.delete();
        guard = 0;
        while (!(exp_q.size() >= 1 && m_n == 5) && guard < 80) begin feed_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0); guard++; end
        n_checks++; if (bus.byte_valid !== 1'b1 || m_n != 5) begin n_fail++; $display("FAIL rstmid_setup: got valid %0b partial %0d expected 1 and 5", bus.byte_valid, m_n); end
        rst = 1'b1;
        bus.en = 1'b0;
        bus.byte_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.byte_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b expected 0", bus.byte_valid); end
        n_checks++; if (bus.byte_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_byte_out: got %0h expected 0", bus.byte_out); end
        n_checks++; if (bus.drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rstmid_drop: got %0d expected 0", bus.drop_cnt); end
        n_checks++; if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL rstmid_health: got %0b expected 0", bus.health_fail); end
        rst = 1'b0;
        model_reset();
        got_q.delete();
        @(negedge clk);
        v = 8'($urandom_range(0, 255));
        feed_seq({56'h0, v}, 8);
        feed_end();
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL rstmid_fresh_count: got %0d bytes expected 1", got_q.size()); end
        n_checks++; if (got_q.size() > 0 && got_q[0] !== v) begin n_fail++; $display("FAIL rstmid_fresh_byte: got %0h expected %0h", got_q[0], v); end
    endtask

    initial begin
        bus.en         = 1'b0;
        bus.rng_in     = 1'b0;
        bus.bypass_vn  = 1'b0;
        bus.clr_fail   = 1'b0;
        bus.byte_ready = 1'b1;
        model_reset();
        test_reset();
        test_debias();
        test_bypass();
        test_random();
        test_backpressure();
        test_drop_saturate();
        test_health();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rng_bit_harvester.md
# rng_bit_harvester

Downstream consumer of the ALFSR digitised output (`rng_out_d`). It synchronises the free-running raw bit, samples it at a programmable rate and runs a repetition-count health test on the raw samples. The samples are then debiased with a von Neumann corrector, packed MSB-first into bytes, and each byte is presented on a single-entry valid/ready output register for the host-side readout logic.

## Interface
Parameters:
- `DIV`, 4: sample period in `clk` cycles, ≥1.
- `RCT_LIMIT`, 32: consecutive identical raw samples that trip the health test, ≥2.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  harvesting enable.
- `rng_in`  in  1  raw ALFSR bit, asynchronous to `clk`.
- `bypass_vn`  in  1  1 = every raw sample goes straight to the packer (no debias).
- `clr_fail`  in  1  one-cycle pulse, clears `health_fail`.
- `byte_ready`  in  1  consumer accepts `byte_out`.
- `byte_out`  out  8  harvested byte.
- `byte_valid`  out  1  `byte_out` holds an unconsumed byte.
- `health_fail`  out  1  sticky repetition-count failure.
- `drop_cnt`  out  8  saturating count of bytes lost to backpressure.

## Operation
- **Synchroniser:** `rng_in` passes through 2 flops (`s1`, `s2`). Only `s2` is used.
- **Prescaler:** `pcnt` runs 0..DIV-1 while `en`=1. Strobe `stb` = `en` && `pcnt`==DIV-1. With `en`=0, `pcnt` is held at 0.
- **Raw sample:** on `stb`, `smp` = `s2`.
- **Repetition test:** runs on raw samples, before debias.
  - `rep_cnt` width is clog2(RCT_LIMIT+1), saturating.
  - On `stb`: if `smp`==`last_smp`, `rep_cnt`++; otherwise `rep_cnt`=1. The first sample after `rst` or `clr_fail` sets `rep_cnt`=1.
  - When `rep_cnt` reaches RCT_LIMIT, `health_fail`←1.
  - `clr_fail` clears `health_fail` and `rep_cnt`. If a trip and `clr_fail` occur in the same cycle, the trip wins.
- **Von Neumann corrector** (`bypass_vn`=0):
  - Phase flag `ph` alternates on each `stb`.
  - `ph`=0: store sample in `first`.
  - `ph`=1: the pair (`first`,`smp`) is evaluated. `10` emits 1, `01` emits 0, `00`/`11` emit nothing.
  - `en`=0 clears `ph`.
- **Bypass** (`bypass_vn`=1): every `stb` emits `smp`. Changing `bypass_vn` clears `ph`.
- **Gating:** emitted bits are discarded while `health_fail`=1.
- **Packer:**
  - `sreg` is 8 bits, filled MSB-first: `sreg` ← {`sreg`[6:0], bit}.
  - `bcnt` runs 0..7. On the 8th bit, the completed byte is {`sreg`[6:0], bit} and `bcnt`←0.
  - Partial bytes are kept across `en`=0 and `health_fail`. Only `rst` discards them.
- **Output register:**
  - A completed byte loads `byte_out` and sets `byte_valid` if `byte_valid`=0, or if `byte_valid`&&`byte_ready` in the same cycle. In that simultaneous case `byte_valid` stays 1 and `byte_out` takes the new byte.
  - If the register is full and not being accepted, the completed byte is dropped and `drop_cnt`++, saturating at 255.
  - Handshake: a transfer occurs when `byte_valid`&&`byte_ready`. `byte_valid` then falls next cycle unless a new byte loads. `byte_out` is stable while `byte_valid`=1 and `byte_ready`=0.
  - The handshake operates independently of `en` and `health_fail`.
- **Reset:** `rst` clears everything. `byte_out`=0x00, `byte_valid`=0, `health_fail`=0, `drop_cnt`=0, `pcnt`=`ph`=`bcnt`=`rep_cnt`=0, `sreg`=0, sync flops=0.

## Timing
- `rng_in` → `s2`: 2 cycles.
- `stb` → repetition-counter update and corrector/packer update: same edge.
- Completing `stb` → `byte_valid`=1: visible the cycle after that edge (1-cycle latency).
- `health_fail` rises the cycle after the tripping `stb`.
- Throughput: at most 1 raw sample per DIV cycles. Debiased output averages ≤1 bit per 4·DIV cycles for unbiased input.
- `rst` asserted mid-byte or mid-handshake: state is cleared on that edge, and `byte_valid`=0 the next cycle regardless of `byte_ready`.

## Test plan
- **Reset:** after `rst`, all outputs are 0. With `en`=0 and `rng_in` toggling, `byte_valid` stays 0 and `rep_cnt` is unchanged.
- **Debias:** DIV=4, `byte_ready`=1. Each raw bit is held DIV cycles, aligned to `stb`. Raw sequence 10 01 10 01 01 10 01 10 → one byte 0xA5, `byte_valid` high for 1 cycle, `drop_cnt`=0. Inserting 00 and 11 pairs between them produces no change.
- **Bypass:** `bypass_vn`=1, raw 1,1,0,0,1,1,1,0 → 0xCE.
- **Backpressure:** `byte_ready`=0, feed 3 full bytes → `byte_out` stays the first byte and `drop_cnt`=2. Then `byte_ready`=1 on the same cycle a 4th byte completes → `byte_valid` stays 1 and `byte_out` shows the 4th byte. Feeding 300 bytes with `byte_ready`=0 saturates `drop_cnt` at 255.
- **Health:** RCT_LIMIT=32, hold `rng_in`=1 → `health_fail`=1 the cycle after the 32nd `stb`, after which no further bytes complete. `clr_fail` pulsed in the same cycle as a trip leaves `health_fail`=1. `clr_fail` pulsed alone clears it, and harvesting resumes with the partial byte intact.
- **Reset mid-operation:** assert `rst` with `bcnt`=5 and `byte_valid`=1 → the next cycle all outputs are 0. A fresh full byte then decodes correctly from bit 0.
